// File: rtl/barrelshift_seq_if.sv
// barrelshift_seq_if: bundles the control inputs and shifter-facing outputs of barrelshift_seq.
//   master modport: drives din, mode_rot, load, start, stop, step, dir;
//                   observes b, sr_sel, sel, busy, wrap.
//   slave modport:  the sequencer side (barrelshift_seq).
// SIZE_BSN must match the sequencer and the downstream shifter.
interface barrelshift_seq_if #(
    parameter int unsigned SIZE_BSN = 4
);
    localparam int unsigned SelW = $clog2(SIZE_BSN);

    logic [SIZE_BSN-1:0] din;
    logic                mode_rot;
    logic                load;
    logic                start;
    logic                stop;
    logic                step;
    logic                dir;
    logic [SIZE_BSN-1:0] b;
    logic                sr_sel;
    logic [SelW-1:0]     sel;
    logic                busy;
    logic                wrap;

    modport master (
        output din, mode_rot, load, start, stop, step, dir,
        input  b, sr_sel, sel, busy, wrap
    );

    modport slave (
        input  din, mode_rot, load, start, stop, step, dir,
        output b, sr_sel, sel, busy, wrap
    );
endinterface

// File: rtl/barrelshift_seq.sv
// barrelshift_seq: sequencer feeding a barrelshifter_n of the same SIZE_BSN.
// Captures a data word and shift/rotate mode on a load edge, then steps the shift amount
// one position per advance, either free-running on a prescaled tick (RUN) or by single
// step edges (HOLD).
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus.din    word captured on load
//   bus.mode_rot  mode captured on load (1 = rotate, 0 = logical shift right)
//   bus.load/start/stop/step  level inputs, acted on at their rising edge
//   bus.dir    0 = sel increments, 1 = sel decrements (sampled at each advance)
//   bus.b, bus.sr_sel, bus.sel  registered shifter controls
//   bus.busy   high while in RUN
//   bus.wrap   one-cycle pulse alongside the first presentation of a wrapped sel
module barrelshift_seq #(
    parameter int unsigned SIZE_BSN = 4,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input logic               clk,
    input logic               rst_n,
    barrelshift_seq_if.slave  bus
);
    localparam int unsigned SelW = $clog2(SIZE_BSN);
    localparam int unsigned CntW = $clog2(TICK_DIV + 1);

    localparam logic [SelW-1:0] SelMax   = SelW'(SIZE_BSN - 1);
    localparam logic [CntW-1:0] TickLast = CntW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StHold, StRun} state_e;

    state_e              state_q, state_d;
    logic [SIZE_BSN-1:0] b_q, b_d;
    logic                sr_sel_q, sr_sel_d;
    logic [SelW-1:0]     sel_q, sel_d;
    logic                wrap_q, wrap_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic load_q, start_q, stop_q, step_q;
    logic load_edge, start_edge, stop_edge, step_edge;
    logic advance;

    assign load_edge  = bus.load  & ~load_q;
    assign start_edge = bus.start & ~start_q;
    assign stop_edge  = bus.stop  & ~stop_q;
    assign step_edge  = bus.step  & ~step_q;

    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        sr_sel_d = sr_sel_q;
        sel_d    = sel_q;
        wrap_d   = 1'b0;
        cnt_d    = '0;
        advance  = 1'b0;

        if (load_edge) begin
            // Load overrides every other edge and aborts RUN.
            b_d      = bus.din;
            sr_sel_d = bus.mode_rot;
            sel_d    = '0;
            state_d  = StHold;
        end else begin
            unique case (state_q)
                StIdle: ;
                StHold: begin
                    if (start_edge) begin
                        state_d = StRun;
                    end else if (step_edge) begin
                        advance = 1'b1;
                    end
                end
                StRun: begin
                    // Stop beats a coincident tick: no advance on the stopping cycle.
                    if (stop_edge) begin
                        state_d = StHold;
                    end else if (cnt_q == TickLast) begin
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // sel wraps modulo SIZE_BSN, which need not be a power of two.
        if (advance) begin
            if (bus.dir) begin
                if (sel_q == '0) begin
                    sel_d  = SelMax;
                    wrap_d = 1'b1;
                end else begin
                    sel_d = sel_q - SelW'(1);
                end
            end else begin
                if (sel_q == SelMax) begin
                    sel_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    sel_d = sel_q + SelW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            b_q      <= '0;
            sr_sel_q <= 1'b0;
            sel_q    <= '0;
            wrap_q   <= 1'b0;
            cnt_q    <= '0;
            load_q   <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            sr_sel_q <= sr_sel_d;
            sel_q    <= sel_d;
            wrap_q   <= wrap_d;
            cnt_q    <= cnt_d;
            load_q   <= bus.load;
            start_q  <= bus.start;
            stop_q   <= bus.stop;
            step_q   <= bus.step;
        end
    end

    assign bus.b      = b_q;
    assign bus.sr_sel = sr_sel_q;
    assign bus.sel    = sel_q;
    assign bus.busy   = (state_q == StRun);
    assign bus.wrap   = wrap_q;
endmodule
